mmio_uart_tx: RTL

Memory-mapped UART transmitter on the processor's data-memory port, downstream of the `arm` core. It decodes the core's `ALUResult`/`MemWrite`/`WriteData` bus and queues bytes in a small FIFO. It serialises them 8N1, LSB first, on `tx`. It returns status on `ReadData`; the top level selects this data over data memory when `Sel` is high.

---
 rtl/mmio_uart_tx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting on the core's data-memory port.
// Bytes are queued in a small FIFO and shifted out LSB first on a registered tx line.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Sel,
    output logic        tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_t;

    txState_t           r_state;
    txState_t           w_nextState;
    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovr;
    logic               r_en;
    logic [BAUD_W-1:0]  r_baud;
    logic [BAUD_W-1:0]  w_baudNext;
    logic [2:0]         r_bitIdx;
    logic [2:0]         w_bitIdxNext;
    logic [7:0]         r_shift;
    logic [7:0]         w_shiftNext;
    logic               r_tx;
    logic               w_txNext;

    logic               w_write;
    logic               w_wrTxData;
    logic               w_wrStatus;
    logic               w_wrCtrl;
    logic               w_full;
    logic               w_empty;
    logic               w_busy;
    logic               w_pop;
    logic               w_pushOk;
    logic               w_drop;
    logic               w_baudEnd;
    logic [31:0]        w_countExt;
    logic [31:0]        w_status;
    logic               w_unused;

    assign Sel        = (ALUResult[31:4] == BASE_ADDR[31:4]);
    assign w_write    = MemWrite && Sel;
    assign w_wrTxData = w_write && (ALUResult[3:2] == 2'd0);
    assign w_wrStatus = w_write && (ALUResult[3:2] == 2'd1);
    assign w_wrCtrl   = w_write && (ALUResult[3:2] == 2'd2);

    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != IDLE);
    assign w_baudEnd  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

    // A full FIFO still takes a byte when the transmitter frees a slot that same cycle.
    assign w_pushOk   = w_wrTxData && (!w_full || w_pop);
    assign w_drop     = w_wrTxData && w_full && !w_pop;

    assign w_countExt = 32'(r_count);
    assign w_status   = {24'b0, w_countExt[3:0], r_ovr, w_busy, w_empty, w_full};
    assign w_unused   = ^{WriteData[31:8], WriteData[6:4], WriteData[2:1],
                          ALUResult[1:0], w_countExt[31:4]};

    always_comb begin
        ReadData = 32'b0;
        if (Sel) begin
            case (ALUResult[3:2])
                2'd1:    ReadData = w_status;
                2'd2:    ReadData = {31'b0, r_en};
                default: ReadData = 32'b0;
            endcase
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_pop        = 1'b0;
        w_shiftNext  = r_shift;
        w_bitIdxNext = r_bitIdx;
        w_baudNext   = r_baud + BAUD_W'(1);
        w_txNext     = 1'b1;
        case (r_state)
            IDLE: begin
                w_baudNext = '0;
                if (r_en && !w_empty) begin
                    w_pop       = 1'b1;
                    w_shiftNext = r_fifo[r_rdPtr];
                    w_nextState = START;
                end
            end
            START: begin
                if (w_baudEnd) begin
                    w_baudNext   = '0;
                    w_bitIdxNext = 3'd0;
                    w_nextState  = DATA;
                end
            end
            DATA: begin
                if (w_baudEnd) begin
                    w_baudNext = '0;
                    if (r_bitIdx == 3'd7) begin
                        w_nextState = STOP;
                    end else begin
                        w_shiftNext  = {1'b0, r_shift[7:1]};
                        w_bitIdxNext = r_bitIdx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (w_baudEnd) begin
                    w_baudNext = '0;
                    if (r_en && !w_empty) begin
                        w_pop       = 1'b1;
                        w_shiftNext = r_fifo[r_rdPtr];
                        w_nextState = START;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
        // The line level is decided from where the FSM is heading so tx stays a pure flop.
        case (w_nextState)
            START:   w_txNext = 1'b0;
            DATA:    w_txNext = w_shiftNext[0];
            default: w_txNext = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bitIdx <= 3'd0;
            r_shift  <= 8'd0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_nextState;
            r_baud   <= w_baudNext;
            r_bitIdx <= w_bitIdxNext;
            r_shift  <= w_shiftNext;
            r_tx     <= w_txNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_pushOk, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_pushOk) begin
            r_fifo[r_wrPtr] <= WriteData[7:0];
        end
    end

    // Overrun set is checked last so it wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovr <= 1'b0;
            r_en  <= 1'b1;
        end else begin
            if (w_wrStatus && WriteData[3]) begin
                r_ovr <= 1'b0;
            end
            if (w_drop) begin
                r_ovr <= 1'b1;
            end
            if (w_wrCtrl) begin
                r_en <= WriteData[0];
            end
        end
    end

    assign tx = r_tx;

endmodule
